// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM request arbiter: response tags, FSM state
// encoding and a small helper for sizing FIFO pointers.
package sram_req_arbiter_pkg;

  // Tag recorded for each accepted request so responses can be routed back
  localparam logic TAG_INST = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  // Arbiter FSM encoding
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] HOLD_INST = 2'd1;
  localparam logic [1:0] HOLD_DATA = 2'd2;

  // Pointer width for a FIFO of the given depth; a depth of one still needs a
  // one-bit pointer so the storage index has a legal width.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_req_arbiter_fifo.sv
// sync_tag_fifo: small in-order tag FIFO with synchronous active-low reset.
// A push is allowed on a full FIFO only when a pop happens in the same cycle,
// which lets the count stay unchanged on simultaneous push and pop.
module sync_tag_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_tag,
  input  logic             pop,
  output logic [WIDTH-1:0] head_tag,
  output logic             full,
  output logic             empty
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_tag = slots[rd_ptr];

  // Write pointer advances on every accepted push, wrapping at the depth
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
    end else if (do_push) begin
      wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on every pop of a non-empty FIFO, wrapping likewise
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
    end else if (do_pop) begin
      rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Occupancy tracks push minus pop; simultaneous push and pop leaves it alone
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage needs no reset; stale slots are never read while empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      slots[wr_ptr] <= push_tag;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like memory port between instruction
// fetch and data access. Requests are arbitrated with a starvation guard for
// fetch, a granted request is held until memory accepts it, and in-order
// responses are routed back using a tag FIFO.
// Optional performance counters are built when SRAM_REQ_ARBITER_PERF_EN is
// defined; the default build leaves them out entirely.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
`ifdef SRAM_REQ_ARBITER_PERF_EN
  output logic [31:0] perf_inst_wait,
  output logic [31:0] perf_data_wait,
  output logic [31:0] perf_full,
`endif
  output logic        err
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [SW-1:0] starve_cnt;
  logic          grant_inst;
  logic          grant_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_head;
  logic          fifo_push;
  logic          fifo_push_tag;
  logic          fifo_pop;

  // Pick who owns the memory port this cycle; a held grant ignores the other side
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (resetn) begin
      case (state)
        IDLE: begin
          if (!fifo_full) begin
            if (data_req && (!inst_req || (starve_cnt < STARVE_MAX))) begin
              grant_data = 1'b1;
            end else if (inst_req) begin
              grant_inst = 1'b1;
            end
          end
        end
        HOLD_INST: grant_inst = 1'b1;
        HOLD_DATA: grant_data = 1'b1;
        default: begin
          grant_inst = 1'b0;
          grant_data = 1'b0;
        end
      endcase
    end
  end

  // Mux the granted requester's payload onto the memory port; fetches are reads
  always_comb begin
    mem_req   = grant_inst | grant_data;
    mem_wr    = 1'b0;
    mem_wstrb = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (grant_data) begin
      mem_wr    = data_wr;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (grant_inst) begin
      mem_addr  = inst_addr;
    end
  end

  assign inst_addr_ok = mem_addr_ok & mem_req & grant_inst;
  assign data_addr_ok = mem_addr_ok & mem_req & grant_data;

  // Lock the grant when memory stalls the request, release it once accepted
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_data && !mem_addr_ok) begin
          state_next = HOLD_DATA;
        end else if (grant_inst && !mem_addr_ok) begin
          state_next = HOLD_INST;
        end
      end
      HOLD_INST, HOLD_DATA: begin
        if (mem_addr_ok) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Count consecutive cycles fetch waits; saturates so fetch keeps priority
  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!inst_req || inst_addr_ok) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign fifo_push     = inst_addr_ok | data_addr_ok;
  assign fifo_push_tag = data_addr_ok ? TAG_DATA : TAG_INST;
  assign fifo_pop      = resetn & mem_data_ok & !fifo_empty;

  sync_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (fifo_push),
    .push_tag (fifo_push_tag),
    .pop      (fifo_pop),
    .head_tag (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Route each response to the requester whose tag sits at the FIFO head
  always_comb begin
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    data_rdata   = 32'h0;
    if (fifo_pop) begin
      if (fifo_head == TAG_DATA) begin
        data_data_ok = 1'b1;
        data_rdata   = mem_rdata;
      end else begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem_rdata;
      end
    end
  end

  // A response with nothing outstanding is a protocol error; it stays set until reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if (mem_data_ok && fifo_empty) begin
      err <= 1'b1;
    end
  end

`ifdef SRAM_REQ_ARBITER_PERF_EN
  // Free-running wait and occupancy counters, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_inst_wait <= 32'h0;
      perf_data_wait <= 32'h0;
      perf_full      <= 32'h0;
    end else begin
      if (inst_req && !inst_addr_ok) begin
        perf_inst_wait <= perf_inst_wait + 32'h1;
      end
      if (data_req && !data_addr_ok) begin
        perf_data_wait <= perf_data_wait + 32'h1;
      end
      if (fifo_full) begin
        perf_full <= perf_full + 32'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Testbench for sram_req_arbiter. The bench plays both requesters and the
// memory. A reference model predicts each cycle's port activity from the
// arbitration rules and keeps a word memory that produces the response data;
// expected responses go into a scoreboard queue that a separate monitor
// drains whenever the DUT raises a data_ok.
module tb_sram_req_arbiter;

  localparam int MAX_OUT = 2;
  localparam int LIMIT   = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err;
`ifdef SRAM_REQ_ARBITER_PERF_EN
  logic [31:0] perf_inst_wait;
  logic [31:0] perf_data_wait;
  logic [31:0] perf_full;
`endif

  always #5 clk = ~clk;

  sram_req_arbiter #(
    .MAX_OUTSTANDING (MAX_OUT),
    .STARVE_LIMIT    (LIMIT)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
`ifdef SRAM_REQ_ARBITER_PERF_EN
    .perf_inst_wait (perf_inst_wait),
    .perf_data_wait (perf_data_wait),
    .perf_full      (perf_full),
`endif
    .err          (err)
  );

  typedef struct {
    logic        mem_req;
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        iok;
    logic        dok;
    logic        err;
    logic        has_resp;
  } cyc_t;

  typedef struct {
    logic        to_data;
    logic [31:0] rdata;
  } resp_t;

  cyc_t  cyc_q[$];
  resp_t resp_q[$];
  resp_t out_q[$];

  logic [31:0] mem_a [int unsigned];

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: who owns a stalled request (0 none, 1 inst, 2 data),
  // consecutive fetch denials, sticky error, and requests still waiting.
  int denied       = 0;
  int locked       = 0;
  bit model_err    = 1'b0;
  bit inst_pending = 1'b0;
  bit data_pending = 1'b0;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    int unsigned k;
    k = int'(a[31:2]);
    if (mem_a.exists(k)) return mem_a[k];
    return a ^ 32'hC0DE_1234;
  endfunction

  task automatic memWrite(input logic [31:0] a, input logic [3:0] strb, input logic [31:0] wd);
    logic [31:0] w;
    int unsigned k;
    k = int'(a[31:2]);
    w = memRead(a);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) w[8*b +: 8] = wd[8*b +: 8];
    end
    mem_a[k] = w;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model predicts the cycle's outcome.
  task automatic applyStimulus(
    input bit          rst,
    input bit          want_i, input logic [31:0] ia,
    input bit          want_d, input bit wr, input logic [3:0] strb,
    input logic [31:0] da,     input logic [31:0] wd,
    input bit          aok,    input bit dok,     input logic [31:0] store_ack);
    cyc_t  c;
    resp_t r;
    int    win;
    bit    full, i_acc, d_acc;
    @(posedge clk);
    #1;
    c = '{default: '0};
    if (rst) begin
      resetn      = 1'b0;
      inst_req    = 1'b0;
      data_req    = 1'b0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = 32'h0;
      c.err       = model_err;
      cyc_q.push_back(c);
      out_q.delete();
      locked = 0; denied = 0; model_err = 1'b0;
      inst_pending = 1'b0; data_pending = 1'b0;
      return;
    end
    resetn = 1'b1;
    if (!inst_pending) begin
      inst_req  = want_i;
      inst_addr = ia;
    end
    if (!data_pending) begin
      data_req   = want_d;
      data_wr    = wr;
      data_wstrb = strb;
      data_addr  = da;
      data_wdata = wd;
    end
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = (out_q.size() > 0) ? out_q[0].rdata : $urandom;

    full = (out_q.size() >= MAX_OUT);
    win  = 0;
    if (locked != 0) win = locked;
    else if (!full) begin
      if (data_req && (!inst_req || denied < LIMIT)) win = 2;
      else if (inst_req) win = 1;
    end
    c.mem_req = (win != 0);
    if (win == 2) begin
      c.addr = data_addr; c.wr = data_wr; c.strb = data_wstrb; c.wdata = data_wdata;
    end else if (win == 1) begin
      c.addr = inst_addr;
    end
    i_acc = (win == 1) && aok;
    d_acc = (win == 2) && aok;
    c.iok = i_acc;
    c.dok = d_acc;
    c.err = model_err;

    if (dok) begin
      if (out_q.size() == 0) model_err = 1'b1;
      else begin
        r = out_q.pop_front();
        resp_q.push_back(r);
        c.has_resp = 1'b1;
      end
    end
    if (i_acc) begin
      r.to_data = 1'b0;
      r.rdata   = memRead(inst_addr);
      out_q.push_back(r);
    end
    if (d_acc) begin
      r.to_data = 1'b1;
      if (data_wr) begin
        memWrite(data_addr, data_wstrb, data_wdata);
        r.rdata = store_ack;
      end else begin
        r.rdata = memRead(data_addr);
      end
      out_q.push_back(r);
    end
    locked = (win != 0 && !aok) ? win : 0;
    if (inst_req && !i_acc) denied = (denied < LIMIT) ? denied + 1 : LIMIT;
    else denied = 0;
    inst_pending = inst_req && !i_acc;
    data_pending = data_req && !d_acc;
    cyc_q.push_back(c);
  endtask

  task automatic idleCycle(input bit aok, input bit dok);
    applyStimulus(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, aok, dok, 32'h0);
  endtask

  // Let pending requests and outstanding responses finish, with a cycle bound
  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      if (out_q.size() == 0 && !inst_pending && !data_pending) return;
      idleCycle(1, out_q.size() > 0);
    end
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL drain: %0d responses still outstanding, expected 0", out_q.size());
  endtask

  // Monitor: compare port activity every cycle and pop the scoreboard on responses
  always @(negedge clk) begin
    cyc_t  c;
    resp_t r;
    if (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      checkOutput("mem_req", {31'h0, mem_req}, {31'h0, c.mem_req});
      checkOutput("inst_addr_ok", {31'h0, inst_addr_ok}, {31'h0, c.iok});
      checkOutput("data_addr_ok", {31'h0, data_addr_ok}, {31'h0, c.dok});
      checkOutput("err", {31'h0, err}, {31'h0, c.err});
      if (c.mem_req) begin
        checkOutput("mem_addr", mem_addr, c.addr);
        checkOutput("mem_wr", {31'h0, mem_wr}, {31'h0, c.wr});
        checkOutput("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, c.strb});
        checkOutput("mem_wdata", mem_wdata, c.wdata);
      end
      if (inst_data_ok || data_data_ok) begin
        checkOutput("one_data_ok", {31'h0, inst_data_ok & data_data_ok}, 32'h0);
        if (resp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL spurious_resp: got inst_data_ok=%0b data_data_ok=%0b, expected none",
                   inst_data_ok, data_data_ok);
        end else begin
          r = resp_q.pop_front();
          checkOutput("resp_route", {31'h0, data_data_ok}, {31'h0, r.to_data});
          checkOutput("resp_rdata", data_data_ok ? data_rdata : inst_rdata, r.rdata);
        end
      end else if (c.has_resp) begin
        r = resp_q.pop_front();
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL missing_resp: got no data_ok, expected response %h", r.rdata);
      end
      if (!inst_data_ok) checkOutput("inst_rdata_idle", inst_rdata, 32'h0);
      if (!data_data_ok) checkOutput("data_rdata_idle", data_rdata, 32'h0);
    end
  end

  initial begin
    resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    mem_a[32'h1c00_0000 >> 2] = 32'h0280_0405;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single fetch answered one cycle later
    applyStimulus(0, 1, 32'h1c00_0000, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
    idleCycle(1, 1);

    // Contention: store wins first, fetch follows, responses in the same order
    applyStimulus(0, 1, 32'h1c00_0004, 1, 1, 4'hF, 32'h100, 32'hDEAD_BEEF, 1, 0, 32'h5A5A_0001);
    idleCycle(1, 0);
    idleCycle(1, 1);
    idleCycle(1, 1);

    // Hold: stalled load keeps the port while fetch arrives behind it
    applyStimulus(0, 0, 32'h0, 1, 0, 4'h0, 32'h100, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 32'h1c00_0008, 1, 0, 4'h0, 32'h100, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 32'h1c00_0008, 1, 0, 4'h0, 32'h100, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 32'h1c00_0008, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
    idleCycle(1, 0);
    drain();

    // Starvation: a steady stream of stores cannot lock fetch out forever
    for (int n = 0; n < 12; n++) begin
      applyStimulus(0, n < 10, 32'h1c00_0010, 1, 1, 4'h3, 32'h104 + 32'(4 * (n % 4)),
                    32'(n) * 32'h0101_0101, 1, out_q.size() > 0, 32'hACE0_0000 + 32'(n));
    end
    drain();

    // Full FIFO: no grant while full, pop first, grant on the following cycle
    applyStimulus(0, 1, 32'h1c00_0020, 1, 0, 4'h0, 32'h108, 32'h0, 1, 0, 32'h0);
    idleCycle(1, 0);
    applyStimulus(0, 0, 32'h0, 1, 0, 4'h0, 32'h10C, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 4'h0, 32'h10C, 32'h0, 1, 1, 32'h0);
    idleCycle(1, 1);
    drain();

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      applyStimulus(0,
                    ($urandom % 3) != 0, 32'h1c00_0000 + 32'(($urandom % 16) * 4),
                    ($urandom % 2) != 0, ($urandom % 2) != 0, 4'($urandom),
                    32'h100 + 32'(($urandom % 16) * 4), $urandom,
                    ($urandom % 4) != 0, (out_q.size() > 0) && (($urandom % 3) != 0),
                    $urandom);
    end
    drain();

    // Response with nothing outstanding raises a sticky error
    idleCycle(0, 1);
    idleCycle(0, 0);
    idleCycle(1, 0);

    // Reset with two requests outstanding clears everything
    applyStimulus(0, 1, 32'h1c00_0000, 1, 0, 4'h0, 32'h100, 32'h0, 1, 0, 32'h0);
    idleCycle(1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idleCycle(1, 0);
    applyStimulus(0, 1, 32'h1c00_0000, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
    idleCycle(1, 1);
    idleCycle(1, 1);
    idleCycle(1, 0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
